// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port mem_system arbiter.
package mem_arb_pkg;

  localparam int unsigned AW          = 16;
  localparam int unsigned DW          = 16;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Request payload as presented by a processor port
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
  } mem_req_t;

  // Per-port completion record returned to the processor
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          hit;
    logic          err;
  } mem_resp_t;

  // A request that must never reach memory: both ops at once or an odd address
  function automatic logic req_illegal(input mem_req_t r);
    return (r.rd & r.wr) | r.addr[0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; remembers the last granted index.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       gnt_c_o
);

  logic last_q, last_d;

  // Lone requester wins; a tie goes to the port that was not granted last
  always_comb begin
    gnt_c_o = 1'b0;
    case (req_i)
      2'b01:   gnt_c_o = 1'b0;
      2'b10:   gnt_c_o = 1'b1;
      2'b11:   gnt_c_o = ~last_q;
      default: gnt_c_o = 1'b0;
    endcase
  end

  // History only moves when the owner actually takes a grant
  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      last_d = gnt_c_o;
    end
  end

  // Reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch port (0) and the data port (1),
// one transaction in flight, round-robin grants, registered responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_rd,
  input  logic          req0_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_rd,
  input  logic          req1_wr,
  output logic          resp0_done,
  output logic [DW-1:0] resp0_rdata,
  output logic          resp0_hit,
  output logic          resp0_err,
  output logic          resp1_done,
  output logic [DW-1:0] resp1_rdata,
  output logic          resp1_hit,
  output logic          resp1_err,
  output logic          req0_stall,
  output logic          req1_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_stall,
  input  logic          mem_hit,
  input  logic          mem_err
);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 is_wr_q, is_wr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [1:0]           done_q, done_d;
  mem_resp_t [1:0]      resp_q, resp_d;

  mem_req_t             req0_c, req1_c, sel_c;
  logic [1:0]           req_eff_c;
  logic                 gnt_c;
  logic                 adv_c;
  logic                 timeout_c;
  logic                 unused_mem_stall_c;

  // Stall is the only informational input and does not steer the FSM
  assign unused_mem_stall_c = mem_stall;

  assign req0_c = {req0_addr, req0_wdata, req0_rd, req0_wr};
  assign req1_c = {req1_addr, req1_wdata, req1_rd, req1_wr};

  // A port seeing its done this cycle is still holding the old request; hide it
  assign req_eff_c[PORT_I] = (req0_rd | req0_wr) & ~done_q[PORT_I];
  assign req_eff_c[PORT_D] = (req1_rd | req1_wr) & ~done_q[PORT_D];

  assign adv_c     = (state_q == ST_IDLE) && (|req_eff_c);
  assign sel_c     = (gnt_c == PORT_D) ? req1_c : req0_c;
  assign timeout_c = (state_q == ST_WAIT) && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_eff_c),
    .adv_i   (adv_c),
    .gnt_c_o (gnt_c)
  );

  // Next-state and registered-output logic for the transaction FSM
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 2'b00;
    resp_d      = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_eff_c) begin
          owner_d = gnt_c;
          if (req_illegal(sel_c)) begin
            done_d[gnt_c]     = 1'b1;
            resp_d[gnt_c].hit = 1'b0;
            resp_d[gnt_c].err = 1'b1;
          end else begin
            mem_addr_d  = sel_c.addr;
            mem_wdata_d = sel_c.wdata;
            mem_rd_d    = sel_c.rd;
            mem_wr_d    = sel_c.wr;
            is_wr_d     = sel_c.wr;
            cnt_d       = '0;
            state_d     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (mem_done) begin
          done_d[owner_q]     = 1'b1;
          resp_d[owner_q].hit = mem_hit;
          resp_d[owner_q].err = mem_err;
          if (!is_wr_q) begin
            resp_d[owner_q].rdata = mem_rdata;
          end
          state_d = ST_IDLE;
        end else if (mem_err || timeout_c) begin
          done_d[owner_q]     = 1'b1;
          resp_d[owner_q].hit = 1'b0;
          resp_d[owner_q].err = 1'b1;
          state_d             = ST_IDLE;
        end else if (state_q == ST_ISSUE) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_I;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 2'b00;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

  assign resp0_done  = done_q[PORT_I];
  assign resp0_rdata = resp_q[PORT_I].rdata;
  assign resp0_hit   = resp_q[PORT_I].hit;
  assign resp0_err   = resp_q[PORT_I].err;
  assign resp1_done  = done_q[PORT_D];
  assign resp1_rdata = resp_q[PORT_D].rdata;
  assign resp1_hit   = resp_q[PORT_D].hit;
  assign resp1_err   = resp_q[PORT_D].err;

  // Stall is combinational from the request lines and the registered done
  assign req0_stall  = (req0_rd | req0_wr) & ~done_q[PORT_I];
  assign req1_stall  = (req1_rd | req1_wr) & ~done_q[PORT_D];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand sequences
// for timeout, round-robin alternation and reset during WAIT.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic        resp0_done, resp0_hit, resp0_err, resp1_done, resp1_hit, resp1_err;
  logic [15:0] resp0_rdata, resp1_rdata;
  logic        req0_stall, req1_stall;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_hit, mem_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rd(req0_rd), .req0_wr(req0_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rd(req1_rd), .req1_wr(req1_wr),
    .resp0_done(resp0_done), .resp0_rdata(resp0_rdata), .resp0_hit(resp0_hit), .resp0_err(resp0_err),
    .resp1_done(resp1_done), .resp1_rdata(resp1_rdata), .resp1_hit(resp1_hit), .resp1_err(resp1_err),
    .req0_stall(req0_stall), .req1_stall(req1_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_hit(mem_hit), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [15:0] wdata; logic rd; logic wr; } req_t;
  typedef struct packed { logic [15:0] rdata; logic hit; logic err; } exp_t;
  typedef struct {
    logic port; logic [15:0] addr; logic [15:0] wdata; logic rd; logic wr; int mode;
    logic [15:0] e_rdata; logic e_hit; logic e_err;
  } vec_t;

  req_t preq0[$], preq1[$];
  exp_t exp0[$], exp1[$];
  logic [15:0] issue_log[$];
  logic [15:0] exp_last[2];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_issue = 0, n_done = 0;
  int issue_cyc = 0, done_cyc = 0, drv_cyc = 0;
  int pulse_err = 0, hold_err = 0, stall_err = 0;
  logic done_port = 1'b0;
  logic act0 = 1'b0, act1 = 1'b0;
  logic in_flight = 1'b0, prev_strobe = 1'b0;
  logic [15:0] iss_addr = '0, iss_wdata = '0;
  logic iss_rd = 1'b0, iss_wr = 1'b0;
  // Memory model: mode 0 done, 1 done+err, 2 err only, 3 never answers
  int mmode = 0, lat = 2, pend = 0;
  logic [15:0] m_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3C3);
  endfunction

  // One clock: sample outputs 1 time unit after the edge, then drive the next inputs
  task automatic tick();
    exp_t e;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (resp0_done) begin
      done_cyc = cyc; done_port = 1'b0; n_done++;
      check("resp0_done_expected", 32'(exp0.size() != 0), 32'd1);
      if (exp0.size() != 0) begin
        e = exp0.pop_front();
        check("resp0_rdata", 32'(resp0_rdata), 32'(e.rdata));
        check("resp0_hit", 32'(resp0_hit), 32'(e.hit));
        check("resp0_err", 32'(resp0_err), 32'(e.err));
      end
    end
    if (resp1_done) begin
      done_cyc = cyc; done_port = 1'b1; n_done++;
      check("resp1_done_expected", 32'(exp1.size() != 0), 32'd1);
      if (exp1.size() != 0) begin
        e = exp1.pop_front();
        check("resp1_rdata", 32'(resp1_rdata), 32'(e.rdata));
        check("resp1_hit", 32'(resp1_hit), 32'(e.hit));
        check("resp1_err", 32'(resp1_err), 32'(e.err));
      end
    end
    if (req0_stall !== ((req0_rd | req0_wr) & ~resp0_done)) stall_err++;
    if (req1_stall !== ((req1_rd | req1_wr) & ~resp1_done)) stall_err++;
    if (resp0_done || resp1_done) in_flight = 1'b0;
    if (mem_rd || mem_wr) begin
      if (prev_strobe) pulse_err++;
      if (mem_rd && mem_wr) pulse_err++;
      n_issue++; issue_cyc = cyc;
      iss_addr = mem_addr; iss_wdata = mem_wdata; iss_rd = mem_rd; iss_wr = mem_wr;
      issue_log.push_back(mem_addr);
      in_flight = 1'b1;
    end else if (in_flight) begin
      if (mem_addr !== iss_addr || mem_wdata !== iss_wdata) hold_err++;
    end
    prev_strobe = mem_rd | mem_wr;
    // memory model
    mem_done = 1'b0; mem_err = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rdata = mem_word(m_addr);
        mem_hit   = ~m_addr[1];
        mem_done  = (mmode == 0) || (mmode == 1);
        mem_err   = (mmode == 1) || (mmode == 2);
      end
    end
    if (mem_rd || mem_wr) begin
      pend = (mmode == 3) ? 0 : lat;
      m_addr = mem_addr;
    end
    mem_stall = (pend > 0);
    // requesters: hold until own done, then load the next queued request
    if (resp0_done) begin act0 = 1'b0; req0_rd = 1'b0; req0_wr = 1'b0; end
    if (resp1_done) begin act1 = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0; end
    if (!act0 && preq0.size() != 0) begin
      r = preq0.pop_front();
      req0_addr = r.addr; req0_wdata = r.wdata; req0_rd = r.rd; req0_wr = r.wr;
      act0 = 1'b1; drv_cyc = cyc;
    end
    if (!act1 && preq1.size() != 0) begin
      r = preq1.pop_front();
      req1_addr = r.addr; req1_wdata = r.wdata; req1_rd = r.rd; req1_wr = r.wr;
      act1 = 1'b1; drv_cyc = cyc;
    end
  endtask

  task automatic enqueue(input logic p, input req_t r, input exp_t e);
    if (p) begin preq1.push_back(r); exp1.push_back(e); end
    else   begin preq0.push_back(r); exp0.push_back(e); end
  endtask

  // Expected completion from the bench's memory model and current mode
  task automatic push_model(input logic p, input logic [15:0] a, input logic [15:0] wd,
                            input logic rd, input logic wr);
    exp_t e;
    if ((rd && wr) || a[0] || mmode >= 2) begin
      e.rdata = exp_last[p]; e.hit = 1'b0; e.err = 1'b1;
    end else begin
      e.rdata = wr ? exp_last[p] : mem_word(a);
      e.hit   = ~a[1];
      e.err   = (mmode == 1);
    end
    exp_last[p] = e.rdata;
    enqueue(p, {a, wd, rd, wr}, e);
  endtask

  task automatic clear_bench();
    preq0.delete(); preq1.delete(); exp0.delete(); exp1.delete();
    act0 = 1'b0; act1 = 1'b0;
    req0_rd = 1'b0; req0_wr = 1'b0; req1_rd = 1'b0; req1_wr = 1'b0;
    pend = 0; in_flight = 1'b0; prev_strobe = 1'b0;
    mem_done = 1'b0; mem_err = 1'b0;
    exp_last[0] = '0; exp_last[1] = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((preq0.size() + preq1.size() + exp0.size() + exp1.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(preq0.size() + preq1.size() + exp0.size() + exp1.size()), 32'd0);
    if (n >= 200) begin
      preq0.delete(); preq1.delete(); exp0.delete(); exp1.delete();
    end
  endtask

  vec_t vt[10];
  logic [15:0] alt_exp[6];

  initial begin
    int n0, nd, wait_n;
    logic bad;
    string nm;

    vt[0] = '{1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 0, 16'hBEEF, 1'b1, 1'b0};
    vt[1] = '{1'b1, 16'h0102, 16'h1234, 1'b0, 1'b1, 0, 16'h0000, 1'b0, 1'b0};
    vt[2] = '{1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 0, 16'hC383, 1'b1, 1'b0};
    vt[3] = '{1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 0, 16'hBEEF, 1'b0, 1'b1};
    vt[4] = '{1'b0, 16'h0020, 16'h5555, 1'b1, 1'b1, 0, 16'hBEEF, 1'b0, 1'b1};
    vt[5] = '{1'b0, 16'h1236, 16'h0000, 1'b1, 1'b0, 0, 16'hD1F5, 1'b0, 1'b0};
    vt[6] = '{1'b1, 16'h0200, 16'hABCD, 1'b0, 1'b1, 0, 16'hC383, 1'b1, 1'b0};
    vt[7] = '{1'b1, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 0, 16'h3C3D, 1'b0, 1'b0};
    vt[8] = '{1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 1, 16'hC2C3, 1'b1, 1'b1};
    vt[9] = '{1'b1, 16'h0300, 16'h0000, 1'b1, 1'b0, 2, 16'h3C3D, 1'b0, 1'b1};
    alt_exp[0] = 16'h0A00; alt_exp[1] = 16'h0B00; alt_exp[2] = 16'h0A04;
    alt_exp[3] = 16'h0B04; alt_exp[4] = 16'h0A08; alt_exp[5] = 16'h0B08;

    rst_n = 1'b0;
    req0_addr = '0; req0_wdata = '0; req1_addr = '0; req1_wdata = '0;
    mem_rdata = '0; mem_stall = 1'b0; mem_hit = 1'b0;
    clear_bench();
    repeat (3) tick();
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_mem_wdata", 32'(mem_wdata), 32'd0);
    check("idle_resp_done", 32'({resp0_done, resp1_done}), 32'd0);
    check("idle_resp_rdata", 32'({resp0_rdata, resp1_rdata}), 32'd0);
    check("idle_resp_flags", 32'({resp0_hit, resp0_err, resp1_hit, resp1_err}), 32'd0);
    check("idle_stall", 32'({req0_stall, req1_stall}), 32'd0);

    // single transactions from the table
    foreach (vt[i]) begin
      nm = $sformatf("v%0d", i);
      mmode = vt[i].mode;
      n0 = n_issue;
      enqueue(vt[i].port, {vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].wr},
              {vt[i].e_rdata, vt[i].e_hit, vt[i].e_err});
      exp_last[vt[i].port] = vt[i].e_rdata;
      drain(nm);
      bad = (vt[i].rd && vt[i].wr) || vt[i].addr[0];
      check({nm, "_done_port"}, 32'(done_port), 32'(vt[i].port));
      if (bad) begin
        check({nm, "_reject_issues"}, 32'(n_issue - n0), 32'd0);
        check({nm, "_reject_lat"}, 32'(done_cyc - drv_cyc), 32'd1);
      end else begin
        check({nm, "_issues"}, 32'(n_issue - n0), 32'd1);
        check({nm, "_grant_lat"}, 32'(issue_cyc - drv_cyc), 32'd1);
        check({nm, "_done_lat"}, 32'(done_cyc - issue_cyc), 32'(lat + 1));
        check({nm, "_mem_addr"}, 32'(iss_addr), 32'(vt[i].addr));
        check({nm, "_mem_op"}, 32'({iss_rd, iss_wr}), 32'({vt[i].rd, vt[i].wr}));
        if (vt[i].wr) check({nm, "_mem_wdata"}, 32'(iss_wdata), 32'(vt[i].wdata));
      end
      tick(); tick();
    end

    // timeout: no mem_done ever, then a normal read
    mmode = 3;
    push_model(1'b0, 16'h0050, 16'h0000, 1'b1, 1'b0);
    drain("timeout");
    check("timeout_lat", 32'(done_cyc - issue_cyc), 32'(TO + 1));
    mmode = 0;
    n0 = n_issue;
    push_model(1'b0, 16'h0054, 16'h0000, 1'b1, 1'b0);
    drain("after_timeout");
    check("after_timeout_issues", 32'(n_issue - n0), 32'd1);

    // both ports requesting from reset: grants alternate starting with port 0
    rst_n = 1'b0;
    clear_bench();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue_log.delete();
    for (int k = 0; k < 3; k++) begin
      push_model(1'b0, 16'h0A00 + 16'(4 * k), 16'h0000, 1'b1, 1'b0);
      push_model(1'b1, 16'h0B00 + 16'(4 * k), 16'h0000, 1'b1, 1'b0);
    end
    drain("alternate");
    check("alt_issue_count", 32'(issue_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < issue_log.size()) check($sformatf("alt_order%0d", k), 32'(issue_log[k]), 32'(alt_exp[k]));
    end
    tick();

    // reset asserted while waiting on memory
    mmode = 3;
    preq0.push_back({16'h0060, 16'h0000, 1'b1, 1'b0});
    n0 = n_issue;
    wait_n = 0;
    while (n_issue == n0 && wait_n < 50) begin tick(); wait_n++; end
    check("rst_wait_issued", 32'(n_issue - n0), 32'd1);
    tick(); tick();
    check("pre_rst_mem_addr", 32'(mem_addr), 32'h0060);
    rst_n = 1'b0;
    #2;
    check("async_mem_addr", 32'(mem_addr), 32'd0);
    check("async_resp0_rdata", 32'(resp0_rdata), 32'd0);
    check("async_resp1_rdata", 32'(resp1_rdata), 32'd0);
    check("async_done", 32'({resp0_done, resp1_done}), 32'd0);
    clear_bench();
    mmode = 0;
    nd = n_done;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_no_done", 32'(n_done - nd), 32'd0);
    n0 = n_issue;
    push_model(1'b0, 16'h0070, 16'h0000, 1'b1, 1'b0);
    drain("after_reset");
    check("after_reset_issues", 32'(n_issue - n0), 32'd1);
    tick(); tick();

    check("strobe_pulse_width", 32'(pulse_err), 32'd0);
    check("addr_data_held", 32'(hold_err), 32'd0);
    check("stall_behaviour", 32'(stall_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
